// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared constants, key codes, state and cursor-op types for the text RAM writer
package vmem_pkg;

    localparam int DEF_COLS = 70;
    localparam int DEF_ROWS = 30;

    // Address packing: mem_addr = {x[X_W-1:0], y[Y_W-1:0]}
    localparam int X_W = 7;
    localparam int Y_W = 5;
    localparam int A_W = X_W + Y_W;

    localparam logic [7:0] KEY_ENTER     = 8'h0A;
    localparam logic [7:0] KEY_BKSP      = 8'h08;
    localparam logic [7:0] KEY_FF        = 8'h0C;
    localparam logic [7:0] KEY_PRINT_MIN = 8'h20;
    localparam logic [7:0] KEY_PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ALL,
        CLR_LINE
    } vmem_state_e;

    // Operation requested of the cursor datapath in a given cycle
    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_PRINT,
        CUR_ENTER,
        CUR_BKSP,
        CUR_HOME
    } cur_op_e;

    function automatic cur_op_e key_to_op(input logic [7:0] key);
        if (key >= KEY_PRINT_MIN && key <= KEY_PRINT_MAX) return CUR_PRINT;
        else if (key == KEY_ENTER)                        return CUR_ENTER;
        else if (key == KEY_BKSP)                         return CUR_BKSP;
        else if (key == KEY_FF)                           return CUR_HOME;
        else                                              return CUR_NONE;
    endfunction

endpackage

// File: rtl/vmem_cursor.sv
// rtl/vmem_cursor.sv - input cursor register and next-position / write-target datapath
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_op           cursor operation this cycle (cur_op_e encoding, CUR_NONE = hold)
//   o_cur_x/y      current cursor position
//   o_wr_en        the operation writes a cell at (o_wr_x, o_wr_y)
//   o_newline      the operation wraps to a new line (caller clears row o_next_y)
//   o_next_y       cursor row after the operation
module vmem_cursor
    import vmem_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     i_op,
    output logic [X_W-1:0] o_cur_x,
    output logic [Y_W-1:0] o_cur_y,
    output logic           o_wr_en,
    output logic [X_W-1:0] o_wr_x,
    output logic [Y_W-1:0] o_wr_y,
    output logic           o_newline,
    output logic [Y_W-1:0] o_next_y
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] w_nx;
    logic [Y_W-1:0] w_ny;
    logic [Y_W-1:0] w_nl_y;

    // Row reached by a newline; the last row wraps to the top
    assign w_nl_y = (r_y == Y_LAST) ? '0 : r_y + 5'd1;

    always_comb begin
        w_nx      = r_x;
        w_ny      = r_y;
        o_wr_en   = 1'b0;
        o_wr_x    = r_x;
        o_wr_y    = r_y;
        o_newline = 1'b0;
        case (i_op)
            CUR_PRINT: begin
                o_wr_en = 1'b1;
                if (r_x < X_LAST) begin
                    w_nx = r_x + 7'd1;
                end else begin
                    w_nx      = '0;
                    w_ny      = w_nl_y;
                    o_newline = 1'b1;
                end
            end
            CUR_ENTER: begin
                w_nx      = '0;
                w_ny      = w_nl_y;
                o_newline = 1'b1;
            end
            CUR_BKSP: begin
                // Erase the cell we step back onto; no wrap past the home cell
                if (r_x != '0) begin
                    w_nx    = r_x - 7'd1;
                    o_wr_en = 1'b1;
                    o_wr_x  = r_x - 7'd1;
                end else if (r_y != '0) begin
                    w_nx    = X_LAST;
                    w_ny    = r_y - 5'd1;
                    o_wr_en = 1'b1;
                    o_wr_x  = X_LAST;
                    o_wr_y  = r_y - 5'd1;
                end
            end
            CUR_HOME: begin
                w_nx = '0;
                w_ny = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    assign o_cur_x  = r_x;
    assign o_cur_y  = r_y;
    assign o_next_y = w_ny;

endmodule

// File: rtl/vmem_wr_ctrl.sv
// rtl/vmem_wr_ctrl.sv - text RAM write controller: key handshake, cursor, screen/line clear sequencing
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   key_in/key_valid/key_ready ASCII key handshake
//   clr_req                    single-cycle clear-screen request
//   mem_we/mem_addr/mem_wdata  registered write port of the text RAM, addr = {x, y}
//   cur_x, cur_y               cursor position
//   busy                       controller is clearing (not IDLE)
//   cursor_vis                 cursor blink phase
// Optional: define VMEM_WR_CTRL_BLINK_EN to blink cursor_vis every BLINK_CYCLES
// cycles; otherwise cursor_vis is constant 1.
module vmem_wr_ctrl
    import vmem_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
`ifdef VMEM_WR_CTRL_BLINK_EN
    ,
    parameter int BLINK_CYCLES = 25000000
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     key_in,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic           clr_req,
    output logic           mem_we,
    output logic [A_W-1:0] mem_addr,
    output logic [7:0]     mem_wdata,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           busy,
    output logic           cursor_vis
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    vmem_state_e    r_state, w_state_nxt;
    logic [X_W-1:0] r_clr_x, w_clr_x_nxt;
    logic [Y_W-1:0] r_clr_y, w_clr_y_nxt;
    logic           r_we, w_we_nxt;
    logic [A_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]     r_wdata, w_wdata_nxt;

    cur_op_e        w_op;
    logic           w_wr_en;
    logic [X_W-1:0] w_wr_x;
    logic [Y_W-1:0] w_wr_y;
    logic           w_newline;
    logic [Y_W-1:0] w_next_y;

    assign key_ready = (r_state == IDLE) && !clr_req;
    assign busy      = (r_state != IDLE);

    // clr_req homes the cursor from IDLE or from an aborted line clear;
    // otherwise only an accepted key drives the cursor.
    always_comb begin
        w_op = CUR_NONE;
        if (clr_req && (r_state == IDLE || r_state == CLR_LINE)) begin
            w_op = CUR_HOME;
        end else if (r_state == IDLE && key_valid) begin
            w_op = key_to_op(key_in);
        end
    end

    vmem_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (clk),
        .rst_n     (reset),
        .i_op      (w_op),
        .o_cur_x   (cur_x),
        .o_cur_y   (cur_y),
        .o_wr_en   (w_wr_en),
        .o_wr_x    (w_wr_x),
        .o_wr_y    (w_wr_y),
        .o_newline (w_newline),
        .o_next_y  (w_next_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clr_x_nxt = r_clr_x;
        w_clr_y_nxt = r_clr_y;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_wr_en) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {w_wr_x, w_wr_y};
                    w_wdata_nxt = (w_op == CUR_PRINT) ? key_in : 8'h00;
                end
                if (w_op == CUR_HOME) begin
                    w_state_nxt = CLR_ALL;
                    w_clr_x_nxt = '0;
                    w_clr_y_nxt = '0;
                end else if (w_newline) begin
                    w_state_nxt = CLR_LINE;
                    w_clr_x_nxt = '0;
                    w_clr_y_nxt = w_next_y;
                end
            end
            CLR_ALL: begin
                if (clr_req) begin
                    w_clr_x_nxt = '0;
                    w_clr_y_nxt = '0;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {r_clr_x, r_clr_y};
                    w_wdata_nxt = 8'h00;
                    if (r_clr_x == X_LAST) begin
                        w_clr_x_nxt = '0;
                        if (r_clr_y == Y_LAST) begin
                            w_state_nxt = IDLE;
                            w_clr_y_nxt = '0;
                        end else begin
                            w_clr_y_nxt = r_clr_y + 5'd1;
                        end
                    end else begin
                        w_clr_x_nxt = r_clr_x + 7'd1;
                    end
                end
            end
            CLR_LINE: begin
                if (clr_req) begin
                    w_state_nxt = CLR_ALL;
                    w_clr_x_nxt = '0;
                    w_clr_y_nxt = '0;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = {r_clr_x, r_clr_y};
                    w_wdata_nxt = 8'h00;
                    if (r_clr_x == X_LAST) begin
                        w_state_nxt = IDLE;
                        w_clr_x_nxt = '0;
                    end else begin
                        w_clr_x_nxt = r_clr_x + 7'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLR_ALL;
            r_clr_x <= '0;
            r_clr_y <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_clr_x <= w_clr_x_nxt;
            r_clr_y <= w_clr_y_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

`ifdef VMEM_WR_CTRL_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic          w_accept;
    logic [BW-1:0] r_blink_cnt;
    logic          r_vis;

    assign w_accept = key_valid && key_ready;

    // Typing keeps the cursor solid: any accepted key restarts the phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_vis       <= 1'b1;
        end else if (w_accept) begin
            r_blink_cnt <= '0;
            r_vis       <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_vis       <= ~r_vis;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign cursor_vis = r_vis;
`else
    assign cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_vmem_wr_ctrl.sv
// tb/tb_vmem_wr_ctrl.sv - self-checking bench for vmem_wr_ctrl
module tb_vmem_wr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key_in;
    logic        key_valid;
    logic        key_ready;
    logic        clr_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    logic        cursor_vis;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vmem_wr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .clr_req    (clr_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .busy       (busy),
        .cursor_vis (cursor_vis)
    );

    // post: 0 = nothing follows, 1 = line clear of row cy, 2 = full clear
    typedef struct {
        logic [7:0] key;
        logic       we;
        int         ax;
        int         ay;
        logic [7:0] data;
        int         cx;
        int         cy;
        int         post;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [11:0] ad(input int x, input int y);
        return {x[6:0], y[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_cur(input string name, input int x, input int y);
        chk({name, ".cur_x"}, 32'(cur_x), 32'(x));
        chk({name, ".cur_y"}, 32'(cur_y), 32'(y));
    endtask

    // Caller has just passed the edge that entered CLR_ALL (or released reset)
    task automatic check_all_clear(input string tag);
        for (int k = 0; k < 2100; k++) begin
            tick();
            chk($sformatf("%s.we[%0d]", tag, k), 32'(mem_we), 32'd1);
            chk($sformatf("%s.addr[%0d]", tag, k), 32'(mem_addr), 32'(ad(k % 70, k / 70)));
            chk($sformatf("%s.data[%0d]", tag, k), 32'(mem_wdata), 32'd0);
            chk($sformatf("%s.busy[%0d]", tag, k), 32'(busy), (k < 2099) ? 32'd1 : 32'd0);
        end
        chk_cur({tag, ".end"}, 0, 0);
    endtask

    task automatic check_line_clear(input string tag, input int row);
        for (int i = 0; i < 70; i++) begin
            tick();
            chk($sformatf("%s.we[%0d]", tag, i), 32'(mem_we), 32'd1);
            chk($sformatf("%s.addr[%0d]", tag, i), 32'(mem_addr), 32'(ad(i, row)));
            chk($sformatf("%s.data[%0d]", tag, i), 32'(mem_wdata), 32'd0);
            chk($sformatf("%s.ready[%0d]", tag, i), 32'(key_ready), (i < 69) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        int guard = 0;
        while (!key_ready && guard < 5000) begin
            tick();
            guard++;
        end
        if (!key_ready) chk("send_key.ready_timeout", 32'(key_ready), 32'd1);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h41, 1'b1, 0,  0, 8'h41, 1,  0, 0};
        vecs[1]  = '{8'h62, 1'b1, 1,  0, 8'h62, 2,  0, 0};
        vecs[2]  = '{8'h07, 1'b0, 0,  0, 8'h00, 2,  0, 0};
        vecs[3]  = '{8'h08, 1'b1, 1,  0, 8'h00, 1,  0, 0};
        vecs[4]  = '{8'h0A, 1'b0, 0,  0, 8'h00, 0,  1, 1};
        vecs[5]  = '{8'h7E, 1'b1, 0,  1, 8'h7E, 1,  1, 0};
        vecs[6]  = '{8'h7F, 1'b0, 0,  0, 8'h00, 1,  1, 0};
        vecs[7]  = '{8'h20, 1'b1, 1,  1, 8'h20, 2,  1, 0};
        vecs[8]  = '{8'h1F, 1'b0, 0,  0, 8'h00, 2,  1, 0};
        vecs[9]  = '{8'h08, 1'b1, 1,  1, 8'h00, 1,  1, 0};
        vecs[10] = '{8'h08, 1'b1, 0,  1, 8'h00, 0,  1, 0};
        vecs[11] = '{8'h08, 1'b1, 69, 0, 8'h00, 69, 0, 0};
        vecs[12] = '{8'h5A, 1'b1, 69, 0, 8'h5A, 0,  1, 1};
        vecs[13] = '{8'h08, 1'b1, 69, 0, 8'h00, 69, 0, 0};
        vecs[14] = '{8'h0C, 1'b0, 0,  0, 8'h00, 0,  0, 2};
        vecs[15] = '{8'h08, 1'b0, 0,  0, 8'h00, 0,  0, 0};
        vecs[16] = '{8'h0D, 1'b0, 0,  0, 8'h00, 0,  0, 0};

        reset     = 1'b0;
        key_in    = 8'h00;
        key_valid = 1'b0;
        clr_req   = 1'b0;
        repeat (3) tick();

        chk("rst.busy", 32'(busy), 32'd1);
        chk("rst.we", 32'(mem_we), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.data", 32'(mem_wdata), 32'd0);
        chk("rst.ready", 32'(key_ready), 32'd0);
        chk("rst.vis", 32'(cursor_vis), 32'd1);
        chk_cur("rst", 0, 0);

        reset = 1'b1;
        check_all_clear("init");
        tick();
        chk("idle.we", 32'(mem_we), 32'd0);
        chk("idle.ready", 32'(key_ready), 32'd1);
        chk("idle.busy", 32'(busy), 32'd0);

        for (int v = 0; v < 17; v++) begin
            send_key(vecs[v].key);
            chk($sformatf("vec%0d.we", v), 32'(mem_we), 32'(vecs[v].we));
            if (vecs[v].we) begin
                chk($sformatf("vec%0d.addr", v), 32'(mem_addr), 32'(ad(vecs[v].ax, vecs[v].ay)));
                chk($sformatf("vec%0d.data", v), 32'(mem_wdata), 32'(vecs[v].data));
            end
            chk_cur($sformatf("vec%0d", v), vecs[v].cx, vecs[v].cy);
            if (vecs[v].post == 1) check_line_clear($sformatf("vec%0d.line", v), vecs[v].cy);
            else if (vecs[v].post == 2) check_all_clear($sformatf("vec%0d.all", v));
        end

        // Fill row 0; the 70th key wraps to row 1 and clears it
        for (int i = 0; i < 70; i++) begin
            send_key(8'h30 + 8'(i % 10));
            chk($sformatf("row0.we[%0d]", i), 32'(mem_we), 32'd1);
            chk($sformatf("row0.addr[%0d]", i), 32'(mem_addr), 32'(ad(i, 0)));
            chk($sformatf("row0.data[%0d]", i), 32'(mem_wdata), 32'(8'h30 + 8'(i % 10)));
        end
        chk_cur("row0.wrap", 0, 1);
        check_line_clear("row0.line1", 1);

        // ENTER down to the last row, then wrap to the top
        for (int r = 2; r < 30; r++) begin
            send_key(8'h0A);
            chk($sformatf("enter%0d.we", r), 32'(mem_we), 32'd0);
            chk_cur($sformatf("enter%0d", r), 0, r);
            check_line_clear($sformatf("enter%0d.line", r), r);
        end
        send_key(8'h0A);
        chk("enter_wrap.we", 32'(mem_we), 32'd0);
        chk_cur("enter_wrap", 0, 0);
        check_line_clear("enter_wrap.line", 0);

        // Backspace at (3,5) and at (0,5)
        repeat (5) send_key(8'h0A);
        send_key(8'h78);
        send_key(8'h79);
        send_key(8'h7A);
        chk_cur("at35", 3, 5);
        send_key(8'h08);
        chk("bs35.we", 32'(mem_we), 32'd1);
        chk("bs35.addr", 32'(mem_addr), 32'(ad(2, 5)));
        chk("bs35.data", 32'(mem_wdata), 32'd0);
        chk_cur("bs35", 2, 5);
        send_key(8'h08);
        send_key(8'h08);
        send_key(8'h08);
        chk("bs05.we", 32'(mem_we), 32'd1);
        chk("bs05.addr", 32'(mem_addr), 32'(ad(69, 4)));
        chk_cur("bs05", 69, 4);

        // clr_req during a line clear aborts it into a full clear
        send_key(8'h0A);
        chk_cur("abort.pre", 0, 5);
        repeat (5) tick();
        chk("abort.busy_pre", 32'(busy), 32'd1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("abort.busy", 32'(busy), 32'd1);
        chk_cur("abort", 0, 0);
        check_all_clear("abort");

        // clr_req in IDLE, then again mid-clear restarts the sweep
        send_key(8'h6B);
        chk_cur("restart.pre", 1, 0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk_cur("restart.home", 0, 0);
        repeat (300) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check_all_clear("restart");

        // Key held together with clr_req waits out the whole clear
        tick();
        send_key(8'h6D);
        chk_cur("hold.pre", 1, 0);
        key_in    = 8'h51;
        key_valid = 1'b1;
        clr_req   = 1'b1;
        #1;
        chk("hold.ready_clr", 32'(key_ready), 32'd0);
        tick();
        clr_req = 1'b0;
        chk("hold.we", 32'(mem_we), 32'd0);
        chk_cur("hold.home", 0, 0);
        check_all_clear("hold");
        chk("hold.ready_after", 32'(key_ready), 32'd1);
        tick();
        key_valid = 1'b0;
        chk("hold.key_we", 32'(mem_we), 32'd1);
        chk("hold.key_addr", 32'(mem_addr), 32'(ad(0, 0)));
        chk("hold.key_data", 32'(mem_wdata), 32'h51);
        chk_cur("hold.key", 1, 0);
        tick();
        chk("hold.idle_we", 32'(mem_we), 32'd0);

        // Asynchronous reset in the middle of a line clear
        send_key(8'h0A);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("rstmid.busy", 32'(busy), 32'd1);
        chk("rstmid.we", 32'(mem_we), 32'd0);
        chk("rstmid.addr", 32'(mem_addr), 32'd0);
        chk_cur("rstmid", 0, 0);
        tick();
        reset = 1'b1;
        check_all_clear("rstmid");
        chk("rstmid.vis", 32'(cursor_vis), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vmem_wr_ctrl.md
Name: vmem_wr_ctrl

Overview:
Write-side controller for the text-mode video memory: a 70x30 character grid of 8-bit ASCII cells, addressed {x[6:0], y[4:0]}. It accepts ASCII keystrokes through a valid/ready handshake and maintains the input cursor. It interprets ENTER, BACKSPACE and form-feed, and sequences whole-screen and single-line clears. It is the only writer of the text RAM's single write port; the VGA read path is unaffected.

Parameters:
COLS, 70, characters per row; legal x is 0..COLS-1.
ROWS, 30, rows per screen; legal y is 0..ROWS-1.
BLINK_CYCLES, 25000000, half-period of the cursor blink in clk cycles (optional feature only).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
key_in  input  8  ASCII code from the PS/2 decoder.
key_valid  input  1  key_in is valid this cycle.
key_ready  output  1  controller accepts key_in this cycle.
clr_req  input  1  single-cycle request to clear the screen.
mem_we  output  1  registered write strobe to the text RAM.
mem_addr  output  12  registered write address {x, y}.
mem_wdata  output  8  registered write data.
cur_x  output  7  cursor column.
cur_y  output  5  cursor row.
busy  output  1  high whenever state != IDLE.
cursor_vis  output  1  cursor blink phase.

Behaviour:
- States:
  - IDLE: accepting keys.
  - CLR_ALL: clears every cell with x<COLS and y<ROWS. x increments inner, y outer; one cell per cycle; 2100 cycles.
  - CLR_LINE: clears row clr_y, cells x=0..COLS-1; 70 cycles.
- While reset is low:
  - state=CLR_ALL, clear counters=0.
  - cur_x=0, cur_y=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- First rising edge after reset releases: registers the write of cell (0,0).
- Clear writes: mem_wdata=0 and mem_we=1 every cycle. The final cell's write is registered on the same edge that moves state to IDLE.
- Handshake:
  - key_ready = (state==IDLE) && !clr_req.
  - A transfer occurs on an edge where key_valid && key_ready.
  - A key presented while not ready is held by the producer, not dropped.
- Write timing: on the accepting edge, mem_we/mem_addr/mem_wdata and the cursor update are registered together (one-cycle latency). mem_we=0 in IDLE when no key is accepted.
- Printable key (0x20..0x7E):
  - Write key_in at the current (cur_x, cur_y).
  - If cur_x < COLS-1: cur_x+1.
  - Otherwise: newline.
- ENTER (0x0A): no character write; newline.
- Newline:
  - cur_x=0; cur_y = (cur_y==ROWS-1) ? 0 : cur_y+1.
  - Enter CLR_LINE for the new cur_y, starting with x=0 on the next edge.
- BACKSPACE (0x08):
  - If cur_x>0: cur_x-1, and write 0 at the new position.
  - Else if cur_y>0: move to (COLS-1, cur_y-1) and write 0 there.
  - At (0,0): accepted, no write, no move.
- Form-feed (0x0C): cursor to (0,0); enter CLR_ALL from cell 0.
- Any other code: accepted and discarded; no write, no cursor change.
- clr_req:
  - In IDLE: same action as form-feed; it takes priority over a simultaneous key, which is not accepted that cycle.
  - In CLR_LINE: abort the line clear, cursor to (0,0), enter CLR_ALL from 0.
  - In CLR_ALL: restart the counters at 0.
- Widths: cursor arithmetic stays in 7/5 bits. mem_addr = {x, y}. x=127 and y>=30 are never produced.
- Reset mid-operation: immediate return to the reset state; the clear restarts from 0.

Optional Feature:
VMEM_WR_CTRL_BLINK_EN
- Defined:
  - A counter toggles cursor_vis every BLINK_CYCLES cycles.
  - Reset value of cursor_vis is 1.
  - Any accepted key forces cursor_vis=1 and restarts the counter.
- Undefined: cursor_vis is tied to 1 and there is no counter logic.

Decomposition:
- Package vmem_pkg holds:
  - COLS and ROWS defaults.
  - Key codes KEY_ENTER=8'h0A, KEY_BKSP=8'h08, KEY_FF=8'h0C, and the printable range bounds.
  - The state enum {IDLE, CLR_ALL, CLR_LINE}.
  - Address packing helper width constants: X_W=7, Y_W=5.
- Sub-module vmem_cursor: holds cur_x/cur_y and computes the next cursor plus the write target for printable, newline and backspace operations. It is purely a datapath with one register pair.
- The FSM, clear counters and memory-port registers stay in vmem_wr_ctrl.

Test Plan:
- Release reset, hold key_valid=0 -> busy=1 and mem_we=1 for exactly 2100 cycles, covering addresses {0,0}..{69,29} with wdata=0, then busy=0 and key_ready=1.
- After init, send 'A' (0x41) -> next cycle mem_we=1, mem_addr={0,0}, wdata=0x41; cur_x=1.
- Send 70 printable keys on row 0 -> the 70th write goes to {69,0}, cursor becomes (0,1), then 70 clear writes to row 1 with key_ready=0.
- At (0,29) send ENTER -> cursor (0,0), 70 clear writes on row 0, no character write.
- At (3,5) send BKSP -> write 0 to {2,5}, cursor (2,5). At (0,5) send BKSP -> write 0 to {69,4}. At (0,0) send BKSP -> no write.
- During CLR_LINE pulse clr_req, and in a separate run hold key_valid with clr_req in IDLE -> CLR_ALL restarts at {0,0}, cursor (0,0), and the key is accepted only after the 2100-cycle clear.
